// File: rtl/adpll_pkg.sv
// Shared types and default constants for the ADPLL lock controller.
// Optional macro ADPLL_LOCK_HYST_EN (see adpll_lock_controller.sv) changes the LOCKED exit threshold.
package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GAIN_HOLD   = 2'd0,
    GAIN_WIDE   = 2'd1,
    GAIN_NARROW = 2'd2
  } gain_t;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_LOCK_WINDOW  = 2;
  localparam int DEF_ACQ_SETTLE   = 4;
  localparam int DEF_LOCK_COUNT   = 16;
  localparam int DEF_UNLOCK_COUNT = 4;
  localparam int DEF_ACQ_TIMEOUT  = 255;

  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/adpll_lock_controller_phase_err_window.sv
// Saturating |phase error| and window compares; purely combinational.
// in_window: |err| <= LOCK_WINDOW, in_hyst: |err| <= 2*LOCK_WINDOW.
module phase_err_window #(
  parameter int WIDTH       = 8,
  parameter int LOCK_WINDOW = 2
) (
  input  logic signed [WIDTH-1:0] err,
  output logic                    in_window,
  output logic                    in_hyst
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0]   WIN      = (WIDTH+1)'(LOCK_WINDOW);
  localparam logic [WIDTH:0]   HYS      = (WIDTH+1)'(2 * LOCK_WINDOW);

  logic [WIDTH-1:0] mag;

  always_comb begin
    // The most negative code has no positive twin; clamp it to the largest magnitude.
    if ($unsigned(err) == MOST_NEG) begin
      mag = MOST_POS;
    end else if (err[WIDTH-1]) begin
      mag = $unsigned(-err);
    end else begin
      mag = $unsigned(err);
    end
    in_window = ({1'b0, mag} <= WIN);
    in_hyst   = ({1'b0, mag} <= HYS);
  end

endmodule

// File: rtl/adpll_lock_controller.sv
// ADPLL lock state machine: IDLE -> ACQUIRE -> TRACK -> LOCKED, all outputs registered.
// Define ADPLL_LOCK_HYST_EN to use 2*LOCK_WINDOW as the out-of-window threshold in LOCKED.
module adpll_lock_controller
  import adpll_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int LOCK_WINDOW  = DEF_LOCK_WINDOW,
  parameter int ACQ_SETTLE   = DEF_ACQ_SETTLE,
  parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int UNLOCK_COUNT = DEF_UNLOCK_COUNT,
  parameter int ACQ_TIMEOUT  = DEF_ACQ_TIMEOUT
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    pd_valid_i,
  input  logic signed [WIDTH-1:0] pd_clock_cycles_i,
  output logic                    loop_en_o,
  output logic [1:0]              gain_sel_o,
  output logic                    locked_o,
  output logic [1:0]              state_o,
  output logic                    lock_lost_o,
  output logic                    acq_timeout_o
);

  state_t           state_reg, state_next;
  gain_t            gain_reg, gain_next;
  logic [CNT_W-1:0] run_reg, run_next, run_inc;
  logic [CNT_W-1:0] acq_reg, acq_next, acq_inc;
  logic             lost_reg, lost_next;
  logic             tmo_reg, tmo_next;
  logic             loop_en_reg, locked_reg;
  logic             in_window, in_hyst, lock_out;

  phase_err_window #(
    .WIDTH      (WIDTH),
    .LOCK_WINDOW(LOCK_WINDOW)
  ) u_window (
    .err      (pd_clock_cycles_i),
    .in_window(in_window),
    .in_hyst  (in_hyst)
  );

`ifdef ADPLL_LOCK_HYST_EN
  assign lock_out = !in_hyst;
`else
  assign lock_out = !in_window;
`endif

  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    acq_next   = acq_reg;
    lost_next  = 1'b0;
    tmo_next   = 1'b0;
    run_inc    = sat_inc(run_reg);
    acq_inc    = sat_inc(acq_reg);

    if (!enable_i) begin
      state_next = ST_IDLE;
      run_next   = '0;
      acq_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_ACQUIRE;
          run_next   = '0;
          acq_next   = '0;
        end
        ST_ACQUIRE: if (pd_valid_i) begin
          run_next = in_window ? run_inc : '0;
          acq_next = acq_inc;
          if (in_window && run_inc >= CNT_W'(ACQ_SETTLE)) begin
            state_next = ST_TRACK;
            run_next   = '0;
            acq_next   = '0;
          end else if (acq_inc >= CNT_W'(ACQ_TIMEOUT)) begin
            tmo_next = 1'b1;
            run_next = '0;
            acq_next = '0;
          end
        end
        ST_TRACK: if (pd_valid_i) begin
          // Large excursions abandon tracking outright; mild ones only restart the run.
          if (!in_hyst) begin
            state_next = ST_ACQUIRE;
            run_next   = '0;
          end else if (in_window) begin
            if (run_inc >= CNT_W'(LOCK_COUNT)) begin
              state_next = ST_LOCKED;
              run_next   = '0;
            end else begin
              run_next = run_inc;
            end
          end else begin
            run_next = '0;
          end
        end
        ST_LOCKED: if (pd_valid_i) begin
          if (lock_out) begin
            if (run_inc >= CNT_W'(UNLOCK_COUNT)) begin
              state_next = ST_ACQUIRE;
              lost_next  = 1'b1;
              run_next   = '0;
            end else begin
              run_next = run_inc;
            end
          end else begin
            run_next = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    case (state_next)
      ST_IDLE:    gain_next = GAIN_HOLD;
      ST_ACQUIRE: gain_next = GAIN_WIDE;
      default:    gain_next = GAIN_NARROW;
    endcase
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= ST_IDLE;
      gain_reg    <= GAIN_HOLD;
      run_reg     <= '0;
      acq_reg     <= '0;
      lost_reg    <= 1'b0;
      tmo_reg     <= 1'b0;
      loop_en_reg <= 1'b0;
      locked_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gain_reg    <= gain_next;
      run_reg     <= run_next;
      acq_reg     <= acq_next;
      lost_reg    <= lost_next;
      tmo_reg     <= tmo_next;
      loop_en_reg <= (state_next != ST_IDLE);
      locked_reg  <= (state_next == ST_LOCKED);
    end
  end

  assign state_o       = state_reg;
  assign gain_sel_o    = gain_reg;
  assign loop_en_o     = loop_en_reg;
  assign locked_o      = locked_reg;
  assign lock_lost_o   = lost_reg;
  assign acq_timeout_o = tmo_reg;

endmodule

// File: doc/adpll_lock_controller.md
ADPLL_LOCK_CONTROLLER -- requirements
Module: adpll_lock_controller

Interface
REQ-001 SHALL have parameter WIDTH, 8, width of the signed phase-error input.
REQ-002 SHALL have parameter LOCK_WINDOW, 2, maximum in-window |error| in fpga_clk cycles.
REQ-003 SHALL have parameter ACQ_SETTLE, 4, consecutive in-window samples needed to leave ACQUIRE.
REQ-004 SHALL have parameter LOCK_COUNT, 16, consecutive in-window samples needed to leave TRACK.
REQ-005 SHALL have parameter UNLOCK_COUNT, 4, consecutive out-of-window samples needed to leave LOCKED.
REQ-006 SHALL have parameter ACQ_TIMEOUT, 255, maximum samples spent in one acquisition attempt.
REQ-007 SHALL have port fpga_clk_i  in  1  single system clock; all logic on rising edge.
REQ-008 SHALL have port reset_n_i  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port enable_i  in  1  level; high runs the loop, low forces IDLE.
REQ-010 SHALL have port pd_valid_i  in  1  one-cycle strobe, one per reference period.
REQ-011 SHALL have port pd_clock_cycles_i  in  WIDTH  signed phase error from the phase detector.
REQ-012 SHALL have port loop_en_o  out  1  enables the loop filter/DCO update.
REQ-013 SHALL have port gain_sel_o  out  2  0 hold, 1 wide, 2 narrow; 3 never driven.
REQ-014 SHALL have port locked_o  out  1  high only in LOCKED.
REQ-015 SHALL have port state_o  out  2  current state encoding.
REQ-016 SHALL have port lock_lost_o  out  1  one-cycle pulse on LOCKED exit caused by error.
REQ-017 SHALL have port acq_timeout_o  out  1  one-cycle pulse when an acquisition attempt times out.

Function
REQ-018 SHALL implement states IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3.
REQ-019 SHALL evaluate samples only on cycles with pd_valid_i high; other cycles hold counters.
REQ-020 SHALL compute |error| with saturation: -2^(WIDTH-1) maps to 2^(WIDTH-1)-1.
REQ-021 SHALL treat a sample as in-window when |error| <= LOCK_WINDOW.
REQ-022 SHALL register all outputs; a state change is visible on the cycle after the deciding pd_valid_i.
REQ-023 SHALL move IDLE->ACQUIRE on the first cycle enable_i is high.
REQ-024 SHALL drive gain 0 and loop_en_o 0 in IDLE, gain 1 in ACQUIRE, and gain 2 in TRACK/LOCKED, with loop_en_o 1 outside IDLE.
REQ-025 SHALL in ACQUIRE count consecutive in-window samples, reset the count on an out-of-window sample, and go to TRACK at ACQ_SETTLE.
REQ-026 SHALL in ACQUIRE count total samples and, at ACQ_TIMEOUT without exit, pulse acq_timeout_o, clear both counters and stay in ACQUIRE.
REQ-027 SHALL in TRACK go to LOCKED at LOCK_COUNT consecutive in-window samples, and reset the count on an out-of-window sample.
REQ-028 SHALL in TRACK return to ACQUIRE on any sample with |error| > 2*LOCK_WINDOW.
REQ-029 SHALL in LOCKED count consecutive out-of-window samples, reset the count on an in-window sample, and at UNLOCK_COUNT go to ACQUIRE and pulse lock_lost_o.
REQ-030 SHALL clear all counters on every state transition.
REQ-031 SHALL saturate counters at their terminal value and never wrap.
REQ-032 SHALL give enable_i low priority over a simultaneous pd_valid_i: next state is IDLE, counters cleared, and no pulse is emitted.

Reset
REQ-033 SHALL on reset_n_i low immediately force IDLE, clear counters, and drive every output to 0, including mid-operation.
REQ-034 SHALL resume from IDLE on the first rising edge after release, and only when enable_i is high.

Configuration
REQ-035 SHALL, with ADPLL_LOCK_HYST_EN defined, use out-of-window threshold 2*LOCK_WINDOW in LOCKED; without it, use LOCK_WINDOW in all states.

Structure
REQ-036 SHALL take the state enum, gain_sel enum and default parameter constants from shared package adpll_pkg.
REQ-037 SHALL place the abs/saturate/window compare in sub-module phase_err_window (combinational, WIDTH-parameterised).

Verification
REQ-038 SHALL test: enable high, 4 samples of error +1 -> TRACK; 16 more -> LOCKED, with locked_o 1 one cycle after the 20th strobe.
REQ-039 SHALL test: in ACQUIRE, errors +1,+1,+1,+5,+1 -> count restarts and there is no TRACK until 4 consecutive in-window samples.
REQ-040 SHALL test: 255 samples of error 40 -> acq_timeout_o pulses exactly once and the state stays ACQUIRE.
REQ-041 SHALL test: in LOCKED, 4 samples of error -3 -> without the macro lock_lost_o pulses and state is ACQUIRE; with ADPLL_LOCK_HYST_EN the state stays LOCKED.
REQ-042 SHALL test: error -128 (0x80) in TRACK -> treated as 127, giving a return to ACQUIRE.
REQ-043 SHALL test: reset_n_i low for 3 ns mid-LOCKED -> all outputs 0 asynchronously; enable_i dropped together with pd_valid_i -> IDLE with no pulses.
